main_ram_arbiter: RTL and testbench

- Shares the single SDRAM controller port (addr/rd/wr/din/dout/busy/word) among three requesters, replacing the combinational load_done mux in the top level.
- Requesters:
  - p0: SNES core, covering ROM reads and BSRAM read/write.
  - p1: flash game_loader word writes.
  - p2: ESP32 SPI loader/debug byte access.
- Registered command issue, busy-based completion, per-port ack pulse.
- Runs on the SDRAM controller clock.

---
 rtl/main_ram_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_main_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_ram_arbiter.sv
`default_nettype none
// ============================================================================
// main_ram_arbiter : three-requester arbiter in front of the single SDRAM
//                    controller port (registered issue, busy-based completion)
// Optional macro   : ROM_WRITE_PROTECT_EN (adds rom_lock, drops ROM writes)
// Revision         : 1.0
// ============================================================================
module main_ram_arbiter #(
    parameter int AW          = 25,
    parameter int BUSY_WAIT   = 15,
    parameter int P0_PRIORITY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_word,
    input  logic [AW-1:0] p0_addr,
    input  logic [15:0]   p0_wdata,
    output logic          p0_ack,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_word,
    input  logic [AW-1:0] p1_addr,
    input  logic [15:0]   p1_wdata,
    output logic          p1_ack,
    input  logic          p2_req,
    input  logic          p2_we,
    input  logic          p2_word,
    input  logic [AW-1:0] p2_addr,
    input  logic [15:0]   p2_wdata,
    output logic          p2_ack,
`ifdef ROM_WRITE_PROTECT_EN
    input  logic          rom_lock,
`endif
    output logic [15:0]   rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          mem_word,
    output logic [15:0]   mem_din,
    input  logic          mem_busy,
    input  logic [15:0]   mem_dout,
    output logic [1:0]    grant,
    output logic          err
);
    localparam int CW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [2:0] {
        S_DRAIN = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [1:0]    r_rr;
    logic [1:0]    r_owner;
    logic [1:0]    r_grant;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [2:0]    r_ack;
    logic [15:0]   r_rdata;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_rd;
    logic          r_mem_wr;
    logic          r_mem_word;
    logic [15:0]   r_mem_din;
    logic          r_err;

    logic [2:0]    w_req;
    logic [1:0]    w_win;
    logic [2:0]    w_idx;
    logic          w_sel_we;
    logic          w_sel_word;
    logic [AW-1:0] w_sel_addr;
    logic [15:0]   w_sel_wdata;
    logic          w_rom_block;
    logic [2:0]    w_win_oh;
    logic [2:0]    w_owner_oh;

    assign w_req = {p2_req, p1_req, p0_req};

    // Winner selection; the rr pointer names the first candidate to consider
    always_comb begin
        w_win = 2'd0;
        w_idx = 3'd0;
        if (P0_PRIORITY != 0) begin
            if (w_req[0])
                w_win = 2'd0;
            else if (r_rr == 2'd2)
                w_win = w_req[2] ? 2'd2 : 2'd1;
            else
                w_win = w_req[1] ? 2'd1 : 2'd2;
        end else begin
            for (int i = 2; i >= 0; i--) begin
                w_idx = {1'b0, r_rr} + 3'(i);
                if (w_idx >= 3'd3)
                    w_idx = w_idx - 3'd3;
                if (w_req[w_idx[1:0]])
                    w_win = w_idx[1:0];
            end
        end
    end

    always_comb begin
        case (w_win)
            2'd1: begin
                w_sel_we = p1_we; w_sel_word = p1_word;
                w_sel_addr = p1_addr; w_sel_wdata = p1_wdata;
            end
            2'd2: begin
                w_sel_we = p2_we; w_sel_word = p2_word;
                w_sel_addr = p2_addr; w_sel_wdata = p2_wdata;
            end
            default: begin
                w_sel_we = p0_we; w_sel_word = p0_word;
                w_sel_addr = p0_addr; w_sel_wdata = p0_wdata;
            end
        endcase
    end

`ifdef ROM_WRITE_PROTECT_EN
    assign w_rom_block = w_sel_we && rom_lock && !w_sel_addr[AW-1];
`else
    assign w_rom_block = 1'b0;
`endif

    assign w_win_oh   = 3'(3'b001 << w_win);
    assign w_owner_oh = 3'(3'b001 << r_owner);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_DRAIN;
            r_rr       <= 2'd1;
            r_owner    <= 2'd0;
            r_grant    <= 2'd3;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_ack      <= 3'b000;
            r_rdata    <= 16'h0000;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_word <= 1'b0;
            r_mem_din  <= 16'h0000;
            r_err      <= 1'b0;
        end else begin
            r_ack <= 3'b000;
            case (r_state)
                S_DRAIN: begin
                    if (!mem_busy)
                        r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (|w_req) begin
                        r_owner    <= w_win;
                        r_we       <= w_sel_we;
                        r_mem_addr <= w_sel_addr;
                        r_mem_word <= w_sel_word;
                        r_mem_din  <= w_sel_word ? w_sel_wdata
                                                 : {w_sel_wdata[7:0], w_sel_wdata[7:0]};
                        r_cnt      <= '0;
                        if (w_rom_block) begin
                            r_ack   <= w_win_oh;
                            r_state <= S_DONE;
                        end else begin
                            r_grant  <= w_win;
                            r_mem_rd <= !w_sel_we;
                            r_mem_wr <= w_sel_we;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_busy) begin
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_state  <= S_WAIT;
                    end else if (r_cnt == CW'(BUSY_WAIT - 1)) begin
                        // Controller never acknowledged: give up, keep rdata
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_err    <= 1'b1;
                        r_ack    <= w_owner_oh;
                        r_grant  <= 2'd3;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!mem_busy) begin
                        if (!r_we)
                            r_rdata <= mem_dout;
                        r_ack   <= w_owner_oh;
                        r_grant <= 2'd3;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (P0_PRIORITY != 0) begin
                        if (r_owner == 2'd1)
                            r_rr <= 2'd2;
                        else if (r_owner == 2'd2)
                            r_rr <= 2'd1;
                    end else begin
                        r_rr <= (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_DRAIN;
            endcase
        end
    end

    assign p0_ack   = r_ack[0];
    assign p1_ack   = r_ack[1];
    assign p2_ack   = r_ack[2];
    assign rdata    = r_rdata;
    assign mem_addr = r_mem_addr;
    assign mem_rd   = r_mem_rd;
    assign mem_wr   = r_mem_wr;
    assign mem_word = r_mem_word;
    assign mem_din  = r_mem_din;
    assign grant    = r_grant;
    assign err      = r_err;
endmodule
`default_nettype wire

// File: tb/tb_main_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_main_ram_arbiter : scoreboard bench for main_ram_arbiter with a small
//                       SDRAM busy model
// Revision            : 1.0
// ============================================================================
module tb_main_ram_arbiter;
    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          p0_req = 0, p0_we = 0, p0_word = 0;
    logic [AW-1:0] p0_addr = '0;
    logic [15:0]   p0_wdata = '0;
    logic          p1_req = 0, p1_we = 0, p1_word = 0;
    logic [AW-1:0] p1_addr = '0;
    logic [15:0]   p1_wdata = '0;
    logic          p2_req = 0, p2_we = 0, p2_word = 0;
    logic [AW-1:0] p2_addr = '0;
    logic [15:0]   p2_wdata = '0;
    logic          p0_ack, p1_ack, p2_ack;
    logic [15:0]   rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr, mem_word;
    logic [15:0]   mem_din;
    logic          mem_busy = 1'b1;
    logic [15:0]   mem_dout = '0;
    logic [1:0]    grant;
    logic          err;
`ifdef ROM_WRITE_PROTECT_EN
    logic          rom_lock = 1'b0;
`endif
    logic [2:0]    ackv;

    always #5 clk = ~clk;

    main_ram_arbiter #(.AW(AW), .BUSY_WAIT(15), .P0_PRIORITY(1)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_word(p0_word), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_word(p1_word), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack),
        .p2_req(p2_req), .p2_we(p2_we), .p2_word(p2_word), .p2_addr(p2_addr),
        .p2_wdata(p2_wdata), .p2_ack(p2_ack),
`ifdef ROM_WRITE_PROTECT_EN
        .rom_lock(rom_lock),
`endif
        .rdata(rdata), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_word(mem_word), .mem_din(mem_din), .mem_busy(mem_busy),
        .mem_dout(mem_dout), .grant(grant), .err(err)
    );

    assign ackv = {p2_ack, p1_ack, p0_ack};

    // SDRAM model: busy rises the cycle after a command and lasts m_len cycles
    int          m_cnt = 0;
    int          m_len = 6;
    logic        m_force = 1'b1;
    logic        m_never = 1'b0;
    logic [15:0] m_rval = '0;

    always @(posedge clk) begin
        if (m_force) begin
            mem_busy <= 1'b1;
        end else if (m_cnt > 0) begin
            m_cnt    <= m_cnt - 1;
            mem_busy <= (m_cnt > 1);
        end else if ((mem_rd || mem_wr) && !m_never && !mem_busy) begin
            mem_busy <= 1'b1;
            m_cnt    <= m_len;
            mem_dout <= m_rval;
        end else begin
            mem_busy <= 1'b0;
        end
    end

    typedef struct {
        int          port;
        logic [15:0] rdata;
        logic        err;
        int          cmd_cycles;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cmd_cyc = 0;
    logic [15:0] exp_rdata = '0;
    logic        exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack is matched against the next scoreboard entry
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd || mem_wr) begin
                chk("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 0);
                cmd_cyc++;
            end
            if (ackv != 3'b000) begin
                if (q.size() == 0) begin
                    chk("unexpected_ack", {29'd0, ackv}, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ack_port", {29'd0, ackv}, 32'(3'b001 << e.port));
                    chk("ack_rdata", {16'd0, rdata}, {16'd0, e.rdata});
                    chk("ack_err", {31'd0, err}, {31'd0, e.err});
                    chk("cmd_cycles", cmd_cyc, e.cmd_cycles);
                end
                cmd_cyc = 0;
            end
        end
    end

    task automatic set_port(input int p, input logic rq, input logic we, input logic word,
                            input logic [AW-1:0] a, input logic [15:0] wd);
        case (p)
            0: begin p0_req = rq; p0_we = we; p0_word = word; p0_addr = a; p0_wdata = wd; end
            1: begin p1_req = rq; p1_we = we; p1_word = word; p1_addr = a; p1_wdata = wd; end
            default: begin p2_req = rq; p2_we = we; p2_word = word; p2_addr = a; p2_wdata = wd; end
        endcase
    endtask

    task automatic drop_req(input int p);
        case (p)
            0: p0_req = 1'b0;
            1: p1_req = 1'b0;
            default: p2_req = 1'b0;
        endcase
    endtask

    task automatic push_exp(input int p, input logic we, input logic [15:0] rv,
                            input logic issue, input logic tmo);
        exp_t e;
        if (tmo)
            exp_err = 1'b1;
        else if (issue && !we)
            exp_rdata = rv;
        e.port = p;
        e.rdata = exp_rdata;
        e.err = exp_err;
        e.cmd_cycles = !issue ? 0 : (tmo ? 15 : 2);
        q.push_back(e);
    endtask

    task automatic wait_ack(input int p);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (ackv[p]) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("ack_arrived", {31'd0, seen}, 1);
        drop_req(p);
        @(negedge clk);
    endtask

    // Single transaction from an idle arbiter, with a command check one cycle after req
    task automatic txn(input int p, input logic we, input logic word, input logic [AW-1:0] a,
                       input logic [15:0] wd, input logic [15:0] rv,
                       input logic issue, input logic tmo);
        logic [15:0] din;
        din = word ? wd : {wd[7:0], wd[7:0]};
        m_rval = rv;
        push_exp(p, we, rv, issue, tmo);
        set_port(p, 1'b1, we, word, a, wd);
        @(negedge clk);
        if (issue) begin
            chk("cmd_rd", {31'd0, mem_rd}, {31'd0, !we});
            chk("cmd_wr", {31'd0, mem_wr}, {31'd0, we});
            chk("cmd_word", {31'd0, mem_word}, {31'd0, word});
            chk("cmd_addr", 32'(mem_addr), 32'(a));
            chk("cmd_grant", {30'd0, grant}, 32'(p));
            if (we)
                chk("cmd_din", {16'd0, mem_din}, {16'd0, din});
        end else begin
            chk("blocked_no_wr", {31'd0, mem_wr}, 0);
        end
        wait_ack(p);
    endtask

    task automatic multi_test();
        int rem[3];
        int left;
        m_rval = 16'hC3C3;
        push_exp(0, 1'b0, 16'hC3C3, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            push_exp(1, 1'b1, 16'h0, 1'b1, 1'b0);
            push_exp(2, 1'b1, 16'h0, 1'b1, 1'b0);
        end
        rem = '{1, 3, 3};
        set_port(0, 1'b1, 1'b0, 1'b1, 25'h1000020, 16'h0000);
        set_port(1, 1'b1, 1'b1, 1'b1, 25'h0000300, 16'h1111);
        set_port(2, 1'b1, 1'b1, 1'b0, 25'h0000400, 16'h0022);
        left = 7;
        for (int i = 0; i < 500 && left > 0; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (ackv[k] && rem[k] > 0) begin
                    rem[k]--;
                    left--;
                    if (rem[k] == 0)
                        drop_req(k);
                end
            end
        end
        chk("multi_all_acked", left, 0);
        @(negedge clk);
    endtask

    initial begin
        bit bad;
        // Reset with the controller still busy
        repeat (3) @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 3);
        chk("rst_cmd", {30'd0, mem_rd, mem_wr}, 0);
        chk("rst_rdata", {16'd0, rdata}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_ack", {29'd0, ackv}, 0);
        chk("rst_addr_din", {mem_addr[15:0], mem_din}, 0);
        reset = 1'b0;
        push_exp(1, 1'b1, 16'h0, 1'b1, 1'b0);
        set_port(1, 1'b1, 1'b1, 1'b1, 25'h0000040, 16'h1234);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_rd || mem_wr || grant != 2'd3)
                bad = 1;
        end
        chk("drain_quiet", {31'd0, bad}, 0);
        m_force = 1'b0;
        wait_ack(1);

        txn(1, 1'b1, 1'b1, 25'h0000100, 16'hBEEF, 16'h0000, 1'b1, 1'b0);
        txn(0, 1'b0, 1'b0, 25'h1000010, 16'h0000, 16'h5A5A, 1'b1, 1'b0);
        txn(2, 1'b1, 1'b0, 25'h0000500, 16'h0033, 16'h0000, 1'b1, 1'b0);

        multi_test();

        m_never = 1'b1;
        txn(1, 1'b0, 1'b1, 25'h0000600, 16'h0000, 16'hDEAD, 1'b1, 1'b1);
        m_never = 1'b0;
        repeat (5) @(negedge clk);
        chk("err_sticky", {31'd0, err}, 1);
        txn(0, 1'b0, 1'b1, 25'h1000700, 16'h0000, 16'h7E57, 1'b1, 1'b0);

`ifdef ROM_WRITE_PROTECT_EN
        rom_lock = 1'b1;
        txn(2, 1'b1, 1'b1, 25'h0000200, 16'hAAAA, 16'h0000, 1'b0, 1'b0);
        txn(2, 1'b1, 1'b1, 25'h1000200, 16'h5555, 16'h0000, 1'b1, 1'b0);
        rom_lock = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
